// File: rtl/kronos_id_param.sv
// Kronos decode stage: OPIMM/OP/LUI/AUIPC decode, NREG-deep register file, one-entry output register.
// Define KRONOS_ID_BYPASS_EN to forward same-edge writeback data into the operands.
module kronos_id_param #(
  parameter int          NREG        = 32,
  parameter logic [31:0] RESET_PC_OP = 32'h0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        flush,
  input  logic [31:0] ifid_pc,
  input  logic [31:0] ifid_ir,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] idex_op1,
  output logic [31:0] idex_op2,
  output logic        idex_rs1_read,
  output logic        idex_rs2_read,
  output logic [4:0]  idex_rs1,
  output logic [4:0]  idex_rs2,
  output logic        idex_illegal,
  output logic        pipe_out_vld,
  input  logic        pipe_out_rdy,
  input  logic [31:0] regwr_data,
  input  logic [4:0]  regwr_sel,
  input  logic        regwr_en
);

  localparam int AW = $clog2(NREG);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_read;
    logic        rs2_read;
    logic        illegal;
  } pkt_t;

  localparam pkt_t PKT_IDLE = pkt_t'({RESET_PC_OP, RESET_PC_OP, 13'b0});

  state_t      state_reg;
  pkt_t        pkt_reg;
  pkt_t        pkt_next;
  logic [31:0] rf [NREG];
  logic        accept;
  logic        use1;
  logic        use2;
  logic        unused_rd_bits;

  // The destination field is consumed further down the pipe, not here.
  assign unused_rd_bits = ^ifid_ir[11:7];

  // Storage is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (regwr_en && regwr_sel != 5'd0 && {27'b0, regwr_sel} < NREG)
      rf[regwr_sel[AW-1:0]] <= regwr_data;
  end

  function automatic logic in_range(input logic [4:0] idx);
    return {27'b0, idx} < NREG;
  endfunction

  function automatic logic [31:0] read_src(input logic [4:0] idx);
    if (idx == 5'd0 || !in_range(idx))
      return 32'h0;
`ifdef KRONOS_ID_BYPASS_EN
    if (regwr_en && regwr_sel == idx)
      return regwr_data;
`endif
    return rf[idx[AW-1:0]];
  endfunction

  always_comb begin
    pkt_next     = '0;
    use1         = 1'b0;
    use2         = 1'b0;
    pkt_next.rs1 = ifid_ir[19:15];
    pkt_next.rs2 = ifid_ir[24:20];
    case (ifid_ir[6:0])
      OPC_OPIMM: begin
        use1         = 1'b1;
        pkt_next.op1 = read_src(ifid_ir[19:15]);
        pkt_next.op2 = {{20{ifid_ir[31]}}, ifid_ir[31:20]};
      end
      OPC_OP: begin
        use1         = 1'b1;
        use2         = 1'b1;
        pkt_next.op1 = read_src(ifid_ir[19:15]);
        pkt_next.op2 = read_src(ifid_ir[24:20]);
      end
      OPC_LUI: begin
        pkt_next.op2 = {ifid_ir[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        pkt_next.op1 = ifid_pc;
        pkt_next.op2 = {ifid_ir[31:12], 12'b0};
      end
      default: pkt_next.illegal = 1'b1;
    endcase
    if ((use1 && !in_range(ifid_ir[19:15])) || (use2 && !in_range(ifid_ir[24:20])))
      pkt_next.illegal = 1'b1;
    pkt_next.rs1_read = use1 && (ifid_ir[19:15] != 5'd0);
    pkt_next.rs2_read = use2 && (ifid_ir[24:20] != 5'd0);
  end

  assign pipe_in_rdy = ~flush & (~pipe_out_vld | pipe_out_rdy);
  assign accept      = pipe_in_vld & pipe_in_rdy;

  // Going empty also parks the operands at their idle value.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_reg <= EMPTY;
      pkt_reg   <= PKT_IDLE;
    end else if (flush) begin
      state_reg <= EMPTY;
      pkt_reg   <= PKT_IDLE;
    end else if (accept) begin
      state_reg <= FULL;
      pkt_reg   <= pkt_next;
    end else if (state_reg == FULL && pipe_out_rdy) begin
      state_reg <= EMPTY;
      pkt_reg   <= PKT_IDLE;
    end
  end

  assign pipe_out_vld  = (state_reg == FULL);
  assign idex_op1      = pkt_reg.op1;
  assign idex_op2      = pkt_reg.op2;
  assign idex_rs1      = pkt_reg.rs1;
  assign idex_rs2      = pkt_reg.rs2;
  assign idex_rs1_read = pkt_reg.rs1_read;
  assign idex_rs2_read = pkt_reg.rs2_read;
  assign idex_illegal  = pkt_reg.illegal;

endmodule

// File: tb/tb_kronos_id_param.sv
// Bench for kronos_id_param: an RV32I (NREG=32) and an RV32E (NREG=16) instance share one stimulus stream.
// Honours KRONOS_ID_BYPASS_EN the same way the design does.
module tb_kronos_id_param;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        r1;
    logic        r2;
    logic        ill;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rstz;
  logic        flush;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_ir;
  logic        pipe_in_vld;
  logic        pipe_out_rdy;
  logic [31:0] regwr_data;
  logic [4:0]  regwr_sel;
  logic        regwr_en;

  logic        in_rdy  [2];
  logic        out_vld [2];
  logic [31:0] op1     [2];
  logic [31:0] op2     [2];
  logic        r1      [2];
  logic        r2      [2];
  logic [4:0]  s1      [2];
  logic [4:0]  s2      [2];
  logic        ill     [2];

  logic [31:0] refs    [2][32];
  logic        exp_vld;
  pkt_t        exp_pkt [2];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  kronos_id_param #(.NREG(32), .RESET_PC_OP(32'h0)) dut32 (
    .clk(clk), .rstz(rstz), .flush(flush), .ifid_pc(ifid_pc), .ifid_ir(ifid_ir),
    .pipe_in_vld(pipe_in_vld), .pipe_in_rdy(in_rdy[0]),
    .idex_op1(op1[0]), .idex_op2(op2[0]), .idex_rs1_read(r1[0]), .idex_rs2_read(r2[0]),
    .idex_rs1(s1[0]), .idex_rs2(s2[0]), .idex_illegal(ill[0]),
    .pipe_out_vld(out_vld[0]), .pipe_out_rdy(pipe_out_rdy),
    .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en));

  kronos_id_param #(.NREG(16), .RESET_PC_OP(32'h0)) dut16 (
    .clk(clk), .rstz(rstz), .flush(flush), .ifid_pc(ifid_pc), .ifid_ir(ifid_ir),
    .pipe_in_vld(pipe_in_vld), .pipe_in_rdy(in_rdy[1]),
    .idex_op1(op1[1]), .idex_op2(op2[1]), .idex_rs1_read(r1[1]), .idex_rs2_read(r2[1]),
    .idex_rs1(s1[1]), .idex_rs2(s2[1]), .idex_illegal(ill[1]),
    .pipe_out_vld(out_vld[1]), .pipe_out_rdy(pipe_out_rdy),
    .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int nreg_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // Architectural register read as execute should see it in the accept cycle.
  function automatic logic [31:0] mread(input int d, input logic [4:0] idx,
                                        input logic wen, input logic [4:0] wsel, input logic [31:0] wd);
    if (idx == 0 || int'(idx) >= nreg_of(d)) return 32'h0;
`ifdef KRONOS_ID_BYPASS_EN
    if (wen && wsel == idx) return wd;
`endif
    return refs[d][idx];
  endfunction

  function automatic pkt_t mdecode(input int d, input logic [31:0] ir, input logic [31:0] pc,
                                   input logic wen, input logic [4:0] wsel, input logic [31:0] wd);
    pkt_t        p;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] uimm;
    logic [31:0] simm;
    a    = ir[19:15];
    b    = ir[24:20];
    uimm = ir & 32'hFFFF_F000;
    simm = 32'($signed(ir) >>> 20);
    p    = '0;
    p.s1 = a;
    p.s2 = b;
    case (ir[6:0])
      7'h13: begin
        p.op1 = mread(d, a, wen, wsel, wd); p.op2 = simm;
        p.r1 = (a != 0); p.ill = int'(a) >= nreg_of(d);
      end
      7'h33: begin
        p.op1 = mread(d, a, wen, wsel, wd); p.op2 = mread(d, b, wen, wsel, wd);
        p.r1 = (a != 0); p.r2 = (b != 0);
        p.ill = (int'(a) >= nreg_of(d)) || (int'(b) >= nreg_of(d));
      end
      7'h37: p.op2 = uimm;
      7'h17: begin p.op1 = pc; p.op2 = uimm; end
      default: p.ill = 1'b1;
    endcase
    return p;
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_vld[%0d]", d), 32'(out_vld[d]), 32'(exp_vld));
      chk($sformatf("op1[%0d]", d), op1[d], exp_pkt[d].op1);
      chk($sformatf("op2[%0d]", d), op2[d], exp_pkt[d].op2);
      if (exp_vld) begin
        chk($sformatf("rs1[%0d]", d), 32'(s1[d]), 32'(exp_pkt[d].s1));
        chk($sformatf("rs2[%0d]", d), 32'(s2[d]), 32'(exp_pkt[d].s2));
        chk($sformatf("rs1_read[%0d]", d), 32'(r1[d]), 32'(exp_pkt[d].r1));
        chk($sformatf("rs2_read[%0d]", d), 32'(r2[d]), 32'(exp_pkt[d].r2));
        chk($sformatf("illegal[%0d]", d), 32'(ill[d]), 32'(exp_pkt[d].ill));
      end
    end
  endtask

  // One clock of stimulus; called away from the rising edge.
  task automatic step(input logic vld, input logic [31:0] ir, input logic [31:0] pc,
                      input logic ordy, input logic fl,
                      input logic wen, input logic [4:0] wsel, input logic [31:0] wd);
    pkt_t nxt [2];
    logic rdy;
    pipe_in_vld = vld; ifid_ir = ir; ifid_pc = pc; pipe_out_rdy = ordy;
    flush = fl; regwr_en = wen; regwr_sel = wsel; regwr_data = wd;
    #1;
    rdy = !fl && (!exp_vld || ordy);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_rdy[%0d]", d), 32'(in_rdy[d]), 32'(rdy));
      nxt[d] = mdecode(d, ir, pc, wen, wsel, wd);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      exp_vld = 1'b0; exp_pkt[0] = '0; exp_pkt[1] = '0;
    end else if (vld && rdy) begin
      exp_vld = 1'b1; exp_pkt[0] = nxt[0]; exp_pkt[1] = nxt[1];
      $display("accept pc=%h ir=%h", pc, ir);
    end else if (exp_vld && ordy) begin
      exp_vld = 1'b0; exp_pkt[0] = '0; exp_pkt[1] = '0;
    end
    for (int d = 0; d < 2; d++)
      if (wen && wsel != 0 && int'(wsel) < nreg_of(d)) refs[d][wsel] = wd;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[6:0] = 7'h13;
      1: r[6:0] = 7'h33;
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] old5;
    rstz = 1'b0; flush = 1'b0; pipe_in_vld = 1'b0; pipe_out_rdy = 1'b0;
    ifid_pc = '0; ifid_ir = '0; regwr_en = 1'b0; regwr_sel = '0; regwr_data = '0;
    exp_vld = 1'b0; exp_pkt[0] = '0; exp_pkt[1] = '0;
    #12;
    check_outputs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_in_rdy[%0d]", d), 32'(in_rdy[d]), 32'h1);
      chk($sformatf("rst_rs1[%0d]", d), 32'(s1[d]), 32'h0);
      chk($sformatf("rst_rs1_read[%0d]", d), 32'(r1[d]), 32'h0);
      chk($sformatf("rst_illegal[%0d]", d), 32'(ill[d]), 32'h0);
    end
    rstz = 1'b1;
    @(posedge clk); #1;

    for (int i = 1; i < 32; i++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'(i), $urandom);

    // Directed decode cases.
    step(1'b1, 32'h002081B3, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("add_r1", 32'(r1[0]), 32'h1);
    chk("add_r2", 32'(r2[0]), 32'h1);
    step(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("addi_op2", op2[0], 32'hFFFF_FFFF);
    chk("addi_op1", op1[0], 32'h0);
    step(1'b1, 32'h123450B7, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("lui_op2", op2[0], 32'h1234_5000);
    step(1'b1, 32'h00001097, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("auipc_op1", op1[0], 32'h100);
    chk("auipc_op2", op2[0], 32'h1000);

    // Back-pressure then four back-to-back packets.
    for (int i = 0; i < 5; i++)
      step(1'b1, rand_ir(), $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("bp_hold_op1", op1[0], 32'h100);
    for (int i = 0; i < 4; i++)
      step(1'b1, rand_ir(), $urandom, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Same-edge write and read of x5.
    old5 = refs[0][5];
    step(1'b1, 32'h00528033, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef KRONOS_ID_BYPASS_EN
    chk("byp_op1", op1[0], 32'hDEADBEEF);
    chk("byp_op2", op2[1], 32'hDEADBEEF);
`else
    chk("nobyp_op1", op1[0], old5);
`endif

    step(1'b1, 32'h01000033, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("rv32e_ill", 32'(ill[1]), 32'h1);
    chk("rv32e_op2", op2[1], 32'h0);
    chk("rv32i_legal", 32'(ill[0]), 32'h0);
    step(1'b1, 32'h0000007F, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("opc7f_ill", 32'(ill[0]), 32'h1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("x0_op1", op1[0], 32'h0);

    // Flush while FULL with a valid instruction offered.
    step(1'b1, 32'h002081B3, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("flush_vld", 32'(out_vld[0]), 32'h0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_ir(), $urandom, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, 1'($urandom), 5'($urandom), $urandom);

    // Asynchronous reset in the middle of a held packet.
    step(1'b1, 32'h002081B3, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    rstz = 1'b0;
    #1;
    exp_vld = 1'b0; exp_pkt[0] = '0; exp_pkt[1] = '0;
    chk("async_rst_vld32", 32'(out_vld[0]), 32'h0);
    chk("async_rst_vld16", 32'(out_vld[1]), 32'h0);
    #2;
    rstz = 1'b1;
    step(1'b1, 32'h002081B3, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("retained_x1", op1[0], refs[0][1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
